// File: rtl/memory_arbiter.sv
// Arbitrates the single-ported RAM between instruction fetch and data access, data side first.
// Optional ARB_STARVE_GUARD_EN: after STARVE_LIMIT data grants with a fetch waiting, the fetch is served.
module memory_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT_I = 2'd1, GRANT_D = 2'd2} state_t;

    state_t    state, next_state;
    ramstate_t rs;
    logic      dreq;
    logic      force_i;

    assign rs   = ramstate_t'(ramstate);
    assign dreq = dREN | dWEN;

`ifdef ARB_STARVE_GUARD_EN
    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    logic [STREAK_W-1:0] dstreak;

    assign force_i = iREN && (dstreak == STREAK_W'(STARVE_LIMIT));

    // Counts data grants won while a fetch was waiting; any fetch grant or idle fetch side clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dstreak <= '0;
        end else if (state == GRANT_I) begin
            dstreak <= '0;
        end else if (state == IDLE) begin
            if (!iREN)
                dstreak <= '0;
            else if (next_state == GRANT_D)
                dstreak <= dstreak + STREAK_W'(1);
            else if (next_state == GRANT_I)
                dstreak <= '0;
        end
    end
`else
    logic unused_starve_limit;
    assign force_i             = 1'b0;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if (force_i)
                    next_state = GRANT_I;
                else if (dreq)
                    next_state = GRANT_D;
                else if (iREN)
                    next_state = GRANT_I;
            end
            GRANT_D: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                // A dropped request aborts the access; enables have already fallen with it.
                if (!dreq) begin
                    next_state = IDLE;
                end else begin
                    case (rs)
                        ACCESS: begin
                            dwait      = 1'b0;
                            dload      = dWEN ? '0 : ramload;
                            next_state = IDLE;
                        end
                        ERROR: begin
                            err        = 1'b1;
                            next_state = IDLE;
                        end
                        default: ;
                    endcase
                end
            end
            GRANT_I: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    case (rs)
                        ACCESS: begin
                            iwait      = 1'b0;
                            iload      = ramload;
                            next_state = IDLE;
                        end
                        ERROR: begin
                            err        = 1'b1;
                            next_state = IDLE;
                        end
                        default: ;
                    endcase
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_memory_arbiter;

    localparam int LIMIT = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    logic [1:0]  ramstate = 2'd0;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [4:0]  ctl;

    int pass_cnt = 0;
    int total_cnt = 0;

    assign ctl = {ramREN, ramWEN, iwait, dwait, err};

    memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = 2'd0;
        step();
        step();
    endtask

    task automatic test_reset;
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h11; daddr = 32'h22; dstore = 32'h33; ramstate = 2'd2;
        @(negedge CLK);
        total_cnt++; if (ctl !== 5'b00110) $display("FAIL reset_ctl: got %b want %b", ctl, 5'b00110); else pass_cnt++;
        total_cnt++; if ({ramaddr, ramstore} !== 64'h0) $display("FAIL reset_ram: got %h want 0", {ramaddr, ramstore}); else pass_cnt++;
        total_cnt++; if ({iload, dload} !== 64'h0) $display("FAIL reset_load: got %h want 0", {iload, dload}); else pass_cnt++;
        @(posedge CLK);
        #1 RST = 1'b0;
        quiet();
    endtask

    task automatic test_simultaneous;
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h100; daddr = 32'h40; ramstate = 2'd2; ramload = 32'hDEADBEEF;
        @(negedge CLK);
        total_cnt++; if (ctl !== 5'b00110) $display("FAIL sim_arb: got %b want %b", ctl, 5'b00110); else pass_cnt++;
        step();
        @(negedge CLK);
        total_cnt++; if (ctl !== 5'b10100) $display("FAIL sim_dgrant: got %b want %b", ctl, 5'b10100); else pass_cnt++;
        total_cnt++; if (ramaddr !== 32'h40) $display("FAIL sim_daddr: got %h want %h", ramaddr, 32'h40); else pass_cnt++;
        total_cnt++; if (dload !== 32'hDEADBEEF) $display("FAIL sim_dload: got %h want %h", dload, 32'hDEADBEEF); else pass_cnt++;
        step();
        dREN = 1'b0;
        @(negedge CLK);
        total_cnt++; if (ctl !== 5'b00110) $display("FAIL sim_idle: got %b want %b", ctl, 5'b00110); else pass_cnt++;
        step();
        @(negedge CLK);
        total_cnt++; if (ctl !== 5'b10010) $display("FAIL sim_igrant: got %b want %b", ctl, 5'b10010); else pass_cnt++;
        total_cnt++; if ({ramaddr, iload} !== {32'h100, 32'hDEADBEEF}) $display("FAIL sim_iload: got %h want %h", {ramaddr, iload}, {32'h100, 32'hDEADBEEF}); else pass_cnt++;
        quiet();
    endtask

    task automatic test_wait_states;
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234; ramstate = 2'd1;
        @(negedge CLK);
        total_cnt++; if (ctl !== 5'b00110) $display("FAIL ws_arb: got %b want %b", ctl, 5'b00110); else pass_cnt++;
        for (int k = 1; k <= 4; k++) begin
            step();
            ramstate = (k == 4) ? 2'd2 : 2'd1;
            @(negedge CLK);
            total_cnt++; if (ctl !== {3'b011, (k != 4), 1'b0}) $display("FAIL ws_ctl%0d: got %b want %b", k, ctl, {3'b011, (k != 4), 1'b0}); else pass_cnt++;
            total_cnt++; if ({ramaddr, ramstore, dload} !== {32'h80, 32'h1234, 32'h0}) $display("FAIL ws_data%0d: got %h want %h", k, {ramaddr, ramstore, dload}, {32'h80, 32'h1234, 32'h0}); else pass_cnt++;
        end
        step();
        dWEN = 1'b0;
        @(negedge CLK);
        total_cnt++; if (ctl !== 5'b00110) $display("FAIL ws_after: got %b want %b", ctl, 5'b00110); else pass_cnt++;
        quiet();
    endtask

    task automatic test_abort;
        iREN = 1'b1; iaddr = 32'h200; ramstate = 2'd1;
        @(negedge CLK);
        total_cnt++; if (ctl !== 5'b00110) $display("FAIL ab_arb: got %b want %b", ctl, 5'b00110); else pass_cnt++;
        step();
        @(negedge CLK);
        total_cnt++; if (ctl !== 5'b10110) $display("FAIL ab_grant: got %b want %b", ctl, 5'b10110); else pass_cnt++;
        step();
        iREN = 1'b0;
        @(negedge CLK);
        total_cnt++; if (ctl !== 5'b00110) $display("FAIL ab_drop: got %b want %b", ctl, 5'b00110); else pass_cnt++;
        step();
        iREN = 1'b1;
        @(negedge CLK);
        total_cnt++; if (ctl !== 5'b00110) $display("FAIL ab_idle: got %b want %b", ctl, 5'b00110); else pass_cnt++;
        step();
        @(negedge CLK);
        total_cnt++; if (ctl !== 5'b10110 || ramaddr !== 32'h200) $display("FAIL ab_regrant: got %b/%h want %b/%h", ctl, ramaddr, 5'b10110, 32'h200); else pass_cnt++;
        quiet();
    endtask

    task automatic test_error;
        dREN = 1'b1; daddr = 32'h300; ramstate = 2'd3; ramload = 32'hCAFEF00D;
        @(negedge CLK);
        total_cnt++; if (ctl !== 5'b00110) $display("FAIL er_arb: got %b want %b", ctl, 5'b00110); else pass_cnt++;
        step();
        @(negedge CLK);
        total_cnt++; if (ctl !== 5'b10111 || dload !== 32'h0) $display("FAIL er_pulse: got %b/%h want %b/0", ctl, dload, 5'b10111); else pass_cnt++;
        step();
        ramstate = 2'd2;
        @(negedge CLK);
        total_cnt++; if (ctl !== 5'b00110) $display("FAIL er_idle: got %b want %b", ctl, 5'b00110); else pass_cnt++;
        step();
        @(negedge CLK);
        total_cnt++; if (ctl !== 5'b10100 || dload !== 32'hCAFEF00D) $display("FAIL er_retry: got %b/%h want %b/%h", ctl, dload, 5'b10100, 32'hCAFEF00D); else pass_cnt++;
        quiet();
    endtask

    task automatic test_reset_mid;
        dWEN = 1'b1; daddr = 32'h500; dstore = 32'h77; ramstate = 2'd1;
        step();
        @(negedge CLK);
        total_cnt++; if (ctl !== 5'b01110) $display("FAIL rm_grant: got %b want %b", ctl, 5'b01110); else pass_cnt++;
        #1 RST = 1'b1;
        #1;
        total_cnt++; if (ctl !== 5'b00110 || ramaddr !== 32'h0) $display("FAIL rm_async: got %b/%h want %b/0", ctl, ramaddr, 5'b00110); else pass_cnt++;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        total_cnt++; if (ctl !== 5'b00110) $display("FAIL rm_idle: got %b want %b", ctl, 5'b00110); else pass_cnt++;
        step();
        @(negedge CLK);
        total_cnt++; if (ctl !== 5'b01110) $display("FAIL rm_regrant: got %b want %b", ctl, 5'b01110); else pass_cnt++;
        quiet();
    endtask

    task automatic test_starvation;
        byte grants[6];
        int  n = 0;
        bit  saw_i = 0;
        byte want;
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h10; daddr = 32'h20; ramstate = 2'd2;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (!iwait) saw_i = 1;
            if (n < 6 && !dwait) grants[n++] = "D";
            else if (n < 6 && !iwait) grants[n++] = "I";
            step();
        end
        for (int g = 0; g < 6; g++) begin
`ifdef ARB_STARVE_GUARD_EN
            want = ((g % (LIMIT + 1)) == LIMIT) ? "I" : "D";
`else
            want = "D";
`endif
            if (g >= n) grants[g] = "-";
            total_cnt++; if (grants[g] !== want) $display("FAIL starve_grant%0d: got %c want %c", g, grants[g], want); else pass_cnt++;
        end
`ifndef ARB_STARVE_GUARD_EN
        total_cnt++; if (saw_i) $display("FAIL starve_iwait: got iwait low want always high"); else pass_cnt++;
`endif
        quiet();
    endtask

    // Transaction-level model: who owns the RAM (nobody/fetch/data) and how many data wins beat a waiting fetch.
    task automatic test_random;
        int owner = 0;
        int wins = 0;
        int nxt;
        bit guard;
        logic [4:0]  e_ctl;
        logic [31:0] e_addr, e_store, e_il, e_dl;
        for (int c = 0; c < 400; c++) begin
            iREN = ($urandom_range(0, 3) != 0);
            dREN = ($urandom_range(0, 2) == 0);
            dWEN = ($urandom_range(0, 3) == 0);
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            ramstate = 2'($urandom_range(0, 3));
            e_ctl = 5'b00110; e_addr = '0; e_store = '0; e_il = '0; e_dl = '0;
            nxt = owner;
            if (owner == 0) begin
`ifdef ARB_STARVE_GUARD_EN
                guard = iREN && (wins >= LIMIT);
`else
                guard = 0;
`endif
                if (guard) nxt = 1;
                else if (dREN || dWEN) nxt = 2;
                else if (iREN) nxt = 1;
                else nxt = 0;
                if (!iREN) wins = 0;
                else if (nxt == 2) wins = wins + 1;
                else if (nxt == 1) wins = 0;
            end else if (owner == 1) begin
                wins = 0;
                e_addr = iaddr;
                e_ctl[4] = iREN;
                if (!iREN) nxt = 0;
                else if (ramstate == 2'd2) begin e_ctl[2] = 1'b0; e_il = ramload; nxt = 0; end
                else if (ramstate == 2'd3) begin e_ctl[0] = 1'b1; nxt = 0; end
            end else begin
                e_addr = daddr; e_store = dstore;
                e_ctl[3] = dWEN;
                e_ctl[4] = dREN && !dWEN;
                if (!(dREN || dWEN)) nxt = 0;
                else if (ramstate == 2'd2) begin e_ctl[1] = 1'b0; e_dl = dWEN ? 32'h0 : ramload; nxt = 0; end
                else if (ramstate == 2'd3) begin e_ctl[0] = 1'b1; nxt = 0; end
            end
            @(negedge CLK);
            total_cnt++; if (ctl !== e_ctl) $display("FAIL rnd_ctl c%0d: got %b want %b", c, ctl, e_ctl); else pass_cnt++;
            total_cnt++; if ({ramaddr, ramstore} !== {e_addr, e_store}) $display("FAIL rnd_ram c%0d: got %h want %h", c, {ramaddr, ramstore}, {e_addr, e_store}); else pass_cnt++;
            total_cnt++; if ({iload, dload} !== {e_il, e_dl}) $display("FAIL rnd_load c%0d: got %h want %h", c, {iload, dload}, {e_il, e_dl}); else pass_cnt++;
            step();
            owner = nxt;
        end
        quiet();
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_wait_states();
        test_abort();
        test_error();
        test_reset_mid();
        test_starvation();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
